usb_tx: RTL and testbench
=========================

Name: usb_tx

Overview:
Full-speed USB serial transmitter, the transmit counterpart of the SIE receive path.
- Takes a byte stream from the packet layer and drives the bus: SYNC, LSB-first data, bit stuffing, NRZI encoding, then SE0/SE0/J EOP.
- Drives the pad values and the output enable; the SIE owns the tri-state buffers on USB_DP/USB_DN.

Parameters:
- CLK_DIV, 4, clk48 cycles per bit time (48 MHz / 12 Mbps).
- STUFF_LIMIT, 6, consecutive ones after which a zero is inserted.

Ports:
- clk48  input  1  system clock, 48 MHz.
- rst  input  1  synchronous, active-high reset.
- txReqSendPacket  input  1  start request; sampled only in IDLE.
- txData  input  8  next byte, sent LSB first.
- txDataValid  input  1  txData/txIsLastByte are valid.
- txIsLastByte  input  1  the current txData byte is the final byte of the packet.
- txAcceptNewData  output  1  one-cycle pulse: byte latched this cycle.
- txUnderrun  output  1  one-cycle pulse: a packet was aborted because of underrun.
- txBusy  output  1  high from request acceptance until EOP completes.
- dataOutP  output  1  DP pad value.
- dataOutN  output  1  DN pad value.
- outEn  output  1  pad output enable.

Behaviour:
- Reset values: outEn=0, dataOutP=1, dataOutN=0 (J), txAcceptNewData=0, txUnderrun=0, txBusy=0, state=IDLE, bit counter=0.
- Reset during a transfer: abort immediately with no EOP; outEn=0 on the next cycle.
- Bit timing: a phase counter runs 0..CLK_DIV-1 and wraps. Line outputs change only on the cycle where phase==0, so every bit is held exactly CLK_DIV cycles.
- States:
  - IDLE → SYNC, on txReqSendPacket. txBusy and outEn rise on the next cycle, and the first SYNC bit is driven on that same cycle.
  - SYNC: sends 0x80 LSB first (KJKJKJKK).
  - DATA: per byte, 8 bits plus any stuffed bits.
  - EOP_SE0: 2 bit times with P=N=0.
  - EOP_J: 1 bit time of J, then IDLE. outEn and txBusy fall on the cycle after EOP_J ends.
- NRZI encoding: a 0 toggles the line (J↔K); a 1 holds it. Line state after reset is J.
- Bit stuffing:
  - The ones counter starts at 0 and counts from the first SYNC bit; the final SYNC 1 counts.
  - Any 0, real or stuffed, resets the counter.
  - After STUFF_LIMIT consecutive ones, one 0 bit is inserted before the next data bit.
  - A pending stuff bit after the final data bit is sent before EOP.
- Byte handshake:
  - The next byte is latched at phase==0 of bit 7 of the current byte. For the first byte, this is bit 7 of SYNC.
  - The latch occurs only if txDataValid=1; txAcceptNewData pulses on that cycle.
  - No latch occurs if the current byte had txIsLastByte=1; the block proceeds to EOP (or CRC) after that byte.
- Underrun: txDataValid=0 at a latch point while the packet is not finished.
  - Transmit 8 bit times of no-transition (bit-stuff violation), then EOP.
  - txUnderrun pulses at the latch point.
- txReqSendPacket outside IDLE is ignored.
- txData/txIsLastByte are ignored while txDataValid=0.

Optional Feature:
USB_TX_CRC16_EN.
- Enabled:
  - Adds input txAppendCrc16, sampled together with txReqSendPacket.
  - When set, CRC16 is computed over every byte after the first (PID byte). Polynomial 0x8005 reflected (0xA001), init 0xFFFF.
  - After the last byte, the inverted CRC is sent as 16 bits LSB first, stuffed, then EOP.
  - An empty payload yields 0x0000.
- Disabled: the port is absent and the data path ends at the last byte.

Decomposition:
- Shared package usb_packet_pkg holds:
  - SYNC_PATTERN (8'h80), CRC16_POLY_REFL (16'hA001), CRC16_INIT (16'hFFFF).
  - Line-state typedef {J, K, SE0}.
  - usb_tx state enum.
- Natural sub-module: usb_crc16, a serial-per-bit CRC with enable/clear, to be reused by the receive path.

Test Plan:
- ACK PID 0xD2, txIsLastByte=1 → exactly 19 bit times = 76 cycles with outEn=1. Line KJKJKJKK, then NRZI of 0,1,0,0,1,0,1,1, SE0, SE0, J. One txAcceptNewData pulse.
- Single byte 0xFF → one stuffed 0 after the 5th data bit. Total 20 bit times = 80 cycles; the decoded stream matches the input.
- txDataValid dropped before the second byte of a 3-byte packet → txUnderrun pulse, 8 unchanged bit times, then EOP; txBusy falls afterwards.
- rst asserted mid-DATA → next cycle outEn=0, J, txBusy=0. A new request 1 cycle after rst deasserts is accepted and the packet is sent correctly.
- USB_TX_CRC16_EN: PID 0xC3 alone with txAppendCrc16=1 → bytes C3 00 00 on the wire, 35 bit times = 140 cycles.
- txReqSendPacket pulsed during SYNC and during EOP → ignored; exactly one packet emitted.

Source files
------------

// File: rtl/usb_packet_pkg.sv
// Shared USB packet-layer constants and types for the transmit and receive paths.
package usb_packet_pkg;

    localparam logic [7:0]  SYNC_PATTERN    = 8'h80;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

    typedef enum logic [1:0] {
        LS_J,
        LS_K,
        LS_SE0
    } line_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_CRC,
        ST_UNDERRUN,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_t;

endpackage

// File: rtl/usb_tx_if.sv
// Byte-stream handshake between the packet layer (master) and usb_tx (slave).
// USB_TX_CRC16_EN adds txAppendCrc16.
interface usb_tx_if;

    logic       txReqSendPacket;
    logic [7:0] txData;
    logic       txDataValid;
    logic       txIsLastByte;
    logic       txAcceptNewData;
    logic       txUnderrun;
    logic       txBusy;
`ifdef USB_TX_CRC16_EN
    logic       txAppendCrc16;
`endif

    modport master (
`ifdef USB_TX_CRC16_EN
        output txAppendCrc16,
`endif
        output txReqSendPacket, txData, txDataValid, txIsLastByte,
        input  txAcceptNewData, txUnderrun, txBusy
    );

    modport slave (
`ifdef USB_TX_CRC16_EN
        input  txAppendCrc16,
`endif
        input  txReqSendPacket, txData, txDataValid, txIsLastByte,
        output txAcceptNewData, txUnderrun, txBusy
    );

endinterface

// File: rtl/usb_crc16.sv
// Serial (one bit per enable) reflected CRC16, shared by the USB transmit and receive paths.
module usb_crc16
    import usb_packet_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = CRC16_INIT;
        end else if (en_i) begin
            crc_d = (crc_q >> 1) ^ (((crc_q[0] ^ bit_i) == 1'b1) ? CRC16_POLY_REFL : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/usb_tx.sv
// Full-speed USB serial transmitter: SYNC, LSB-first data, bit stuffing, NRZI, SE0/SE0/J EOP.
// Optional CRC16 append is enabled by defining USB_TX_CRC16_EN.
module usb_tx
    import usb_packet_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned STUFF_LIMIT = 6
) (
    input  logic    clk48,
    input  logic    rst,
    usb_tx_if.slave bus,
    output logic    dataOutP,
    output logic    dataOutN,
    output logic    outEn
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned OW = $clog2(STUFF_LIMIT + 1);

    tx_state_t   state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [3:0]  idx_q, idx_d;
    logic [OW-1:0] ones_q, ones_d;
    logic [7:0]  cur_q, cur_d;
    logic        last_q, last_d;
    logic        first_q, first_d;
    logic        crcen_q, crcen_d;
    line_t       line_q, line_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;

    logic        emit, stuff_due, latch_pt, send_bit, tx_bit;
    logic        accept, underrun, crc_clr, crc_feed, append;
    logic [15:0] crc_w;

`ifdef USB_TX_CRC16_EN
    assign append = bus.txAppendCrc16;
`else
    assign append = 1'b0;
`endif

    usb_crc16 u_crc16 (
        .clk   (clk48),
        .rst   (rst),
        .clr_i (crc_clr),
        .en_i  (crc_feed),
        .bit_i (tx_bit),
        .crc_o (crc_w)
    );

    // IDLE keeps phase at 0, so an accepted request emits the first SYNC bit immediately.
    assign emit      = !rst && ((state_q == ST_IDLE) ? bus.txReqSendPacket : (phase_q == '0));
    assign stuff_due = (ones_q == OW'(STUFF_LIMIT));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ones_d   = ones_q;
        cur_d    = cur_q;
        last_d   = last_q;
        first_d  = first_q;
        crcen_d  = crcen_q;
        line_d   = line_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        latch_pt = 1'b0;
        send_bit = 1'b0;
        tx_bit   = 1'b1;
        accept   = 1'b0;
        underrun = 1'b0;
        crc_clr  = 1'b0;
        crc_feed = 1'b0;

        if (emit) begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SYNC;
                    idx_d    = 4'd1;
                    oe_d     = 1'b1;
                    busy_d   = 1'b1;
                    first_d  = 1'b1;
                    last_d   = 1'b0;
                    crcen_d  = append;
                    crc_clr  = 1'b1;
                    send_bit = 1'b1;
                    tx_bit   = SYNC_PATTERN[0];
                end
                ST_SYNC: begin
                    send_bit = 1'b1;
                    tx_bit   = SYNC_PATTERN[idx_q[2:0]];
                    idx_d    = idx_q + 4'd1;
                    latch_pt = (idx_q == 4'd7);
                end
                ST_DATA: begin
                    send_bit = 1'b1;
                    if (stuff_due) begin
                        tx_bit = 1'b0;
                    end else begin
                        tx_bit   = cur_q[idx_q[2:0]];
                        crc_feed = !first_q;
                        idx_d    = idx_q + 4'd1;
                        if (idx_q == 4'd7) begin
                            first_d = 1'b0;
                            if (last_q) begin
                                idx_d   = '0;
                                state_d = crcen_q ? ST_CRC : ST_EOP_SE0;
                            end else begin
                                latch_pt = 1'b1;
                            end
                        end
                    end
                end
                ST_CRC: begin
                    send_bit = 1'b1;
                    if (stuff_due) begin
                        tx_bit = 1'b0;
                    end else begin
                        tx_bit = ~crc_w[idx_q];
                        idx_d  = idx_q + 4'd1;
                        if (idx_q == 4'd15) begin
                            idx_d   = '0;
                            state_d = ST_EOP_SE0;
                        end
                    end
                end
                ST_UNDERRUN: begin
                    // Line held on purpose: eight unchanged bit times violate stuffing.
                    ones_d = '0;
                    idx_d  = idx_q + 4'd1;
                    if (idx_q == 4'd7) begin
                        idx_d   = '0;
                        state_d = ST_EOP_SE0;
                    end
                end
                ST_EOP_SE0: begin
                    if (stuff_due) begin
                        send_bit = 1'b1;
                        tx_bit   = 1'b0;
                    end else if (idx_q < 4'd2) begin
                        line_d = LS_SE0;
                        ones_d = '0;
                        idx_d  = idx_q + 4'd1;
                    end else begin
                        line_d  = LS_J;
                        idx_d   = '0;
                        state_d = ST_EOP_J;
                    end
                end
                ST_EOP_J: begin
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
                default: ;
            endcase

            if (latch_pt) begin
                idx_d = '0;
                if (bus.txDataValid) begin
                    accept  = 1'b1;
                    cur_d   = bus.txData;
                    last_d  = bus.txIsLastByte;
                    state_d = ST_DATA;
                end else begin
                    underrun = 1'b1;
                    state_d  = ST_UNDERRUN;
                end
            end

            if (send_bit) begin
                line_d = tx_bit ? line_q : ((line_q == LS_J) ? LS_K : LS_J);
                ones_d = tx_bit ? (ones_q + 1'b1) : '0;
            end
        end

        if (state_d == ST_IDLE) begin
            phase_d = '0;
        end else if (phase_q == PW'(CLK_DIV - 1)) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            idx_q   <= '0;
            ones_q  <= '0;
            cur_q   <= '0;
            last_q  <= 1'b0;
            first_q <= 1'b0;
            crcen_q <= 1'b0;
            line_q  <= LS_J;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            ones_q  <= ones_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            first_q <= first_d;
            crcen_q <= crcen_d;
            line_q  <= line_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.txAcceptNewData = accept;
    assign bus.txUnderrun      = underrun;
    assign bus.txBusy          = busy_q;
    assign dataOutP            = (line_q == LS_J);
    assign dataOutN            = (line_q == LS_K);
    assign outEn               = oe_q;

endmodule

// File: tb/tb_usb_tx.sv
// Scoreboard bench for usb_tx: the driver queues expected line states and packet summaries,
// a negedge monitor pops and compares them while outEn is high and when it falls.
module tb_usb_tx;

    localparam logic [1:0] LJ = 2'b10;
    localparam logic [1:0] LK = 2'b01;
    localparam logic [1:0] LS = 2'b00;

    typedef struct {
        int len;
        int nacc;
        int nund;
    } pkt_t;

    logic clk48 = 1'b0;
    logic rst   = 1'b1;
    logic dataOutP, dataOutN, outEn;

    usb_tx_if bus();

    usb_tx #(.CLK_DIV(4), .STUFF_LIMIT(6)) dut (
        .clk48    (clk48),
        .rst      (rst),
        .bus      (bus),
        .dataOutP (dataOutP),
        .dataOutN (dataOutN),
        .outEn    (outEn)
    );

    always #5 clk48 = ~clk48;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [1:0] exp_line[$];
    pkt_t       exp_pkt[$];
    logic [1:0] tmp[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_pkt(input int len, input int nacc, input int nund);
        pkt_t p;
        p.len  = len;
        p.nacc = nacc;
        p.nund = nund;
        exp_pkt.push_back(p);
    endtask

    task automatic push_lines(input logic [1:0] q[$], input int count);
        for (int i = 0; i < count && i < q.size(); i++) exp_line.push_back(q[i]);
    endtask

    // Reference encoder: SYNC + bytes, stuffing after six ones (SYNC included), NRZI from J, EOP.
    function automatic void build(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                  input int n);
        logic [7:0] by[3];
        logic       bits[$];
        int         ones;
        logic [1:0] ln;
        by   = '{b0, b1, b2};
        ones = 0;
        ln   = LJ;
        tmp.delete();
        for (int i = 0; i < 8; i++) bits.push_back(i == 7);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 8; i++) bits.push_back(by[k][i]);
        foreach (bits[i]) begin
            if (ones == 6) begin
                ln = ~ln;
                tmp.push_back(ln);
                ones = 0;
            end
            if (bits[i]) begin
                ones++;
            end else begin
                ln   = ~ln;
                ones = 0;
            end
            tmp.push_back(ln);
        end
        if (ones == 6) begin
            ln = ~ln;
            tmp.push_back(ln);
        end
        tmp.push_back(LS);
        tmp.push_back(LS);
        tmp.push_back(LJ);
    endfunction

    // Monitor
    logic       m_prev = 1'b0;
    int         m_cyc  = 0;
    int         m_acc  = 0;
    int         m_und  = 0;
    logic [1:0] m_cur  = 2'b11;

    always @(negedge clk48) begin
        pkt_t p;
        if (outEn === 1'b1) begin
            if (!m_prev) begin
                m_cyc = 0;
                m_acc = 0;
                m_und = 0;
                chk("busy_rise", bus.txBusy, 1);
            end
            if (m_cyc % 4 == 0) begin
                if (exp_line.size() == 0) begin
                    chk("line_extra_bit", exp_line.size(), 1);
                    m_cur = 2'b11;
                end else begin
                    m_cur = exp_line.pop_front();
                end
                chk("line_bit_start", {dataOutP, dataOutN}, m_cur);
            end else if (m_cyc % 4 == 3) begin
                chk("line_bit_hold", {dataOutP, dataOutN}, m_cur);
            end
            m_acc += int'(bus.txAcceptNewData);
            m_und += int'(bus.txUnderrun);
            m_cyc++;
        end else if (m_prev) begin
            if (exp_pkt.size() != 0) p = exp_pkt.pop_front();
            else p = '{-1, -1, -1};
            chk("oe_cycles", m_cyc, p.len);
            chk("accept_pulses", m_acc, p.nacc);
            chk("underrun_pulses", m_und, p.nund);
            chk("busy_fall", bus.txBusy, 0);
            chk("line_idle_J", {dataOutP, dataOutN}, LJ);
        end
        m_prev = (outEn === 1'b1);
    end

`ifdef USB_TX_CRC16_EN
    bit append_req = 1'b0;
`endif

    // Packet-layer driver: request, then present bytes and advance on each accept pulse.
    task automatic send(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input int n, input int ndrop, input bit poke, input int rst_at);
        logic [7:0] by[3];
        int         served;
        logic       acc, bz;
        bit         done;
        by     = '{b0, b1, b2};
        served = 0;
        done   = 1'b0;
        @(posedge clk48); #1;
        bus.txReqSendPacket = 1'b1;
        bus.txDataValid     = (ndrop != 0);
        bus.txData          = b0;
        bus.txIsLastByte    = (n == 1);
`ifdef USB_TX_CRC16_EN
        bus.txAppendCrc16   = append_req;
`endif
        @(posedge clk48); #1;
        bus.txReqSendPacket = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk48);
            acc = bus.txAcceptNewData;
            bz  = bus.txBusy;
            @(posedge clk48); #1;
            bus.txReqSendPacket = poke && (cyc == 2 || cyc == 72);
            if (acc) begin
                served++;
                if (served >= n || served == ndrop) begin
                    bus.txDataValid = 1'b0;
                end else begin
                    bus.txData       = by[served];
                    bus.txIsLastByte = (served == n - 1);
                end
            end
            if (rst_at == cyc) begin
                rst = 1'b1;
            end else if (rst) begin
                rst  = 1'b0;
                done = 1'b1;
            end
            if (!bz && cyc > 2) done = 1'b1;
        end
        chk("send_completed", done, 1);
        bus.txReqSendPacket = 1'b0;
        bus.txDataValid     = 1'b0;
        repeat (3) @(posedge clk48);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] q[$];
        bus.txReqSendPacket = 1'b0;
        bus.txData          = '0;
        bus.txDataValid     = 1'b0;
        bus.txIsLastByte    = 1'b0;
`ifdef USB_TX_CRC16_EN
        bus.txAppendCrc16   = 1'b0;
`endif
        repeat (3) @(posedge clk48);
        @(negedge clk48);
        chk("rst_outEn", outEn, 0);
        chk("rst_dataOutP", dataOutP, 1);
        chk("rst_dataOutN", dataOutN, 0);
        chk("rst_busy", bus.txBusy, 0);
        chk("rst_accept", bus.txAcceptNewData, 0);
        chk("rst_underrun", bus.txUnderrun, 0);
        @(posedge clk48); #1;
        rst = 1'b0;

        // ACK PID, with requests pulsed during SYNC and during EOP
        q = '{LK, LJ, LK, LJ, LK, LJ, LK, LK, LJ, LJ, LK, LJ, LJ, LK, LK, LK, LS, LS, LJ};
        push_lines(q, q.size());
        expect_pkt(76, 1, 0);
        send(8'hD2, 8'h00, 8'h00, 1, -1, 1'b1, -1);

        // 0xFF: one stuffed zero after the fifth data bit
        q = '{LK, LJ, LK, LJ, LK, LJ, LK, LK, LK, LK, LK, LK, LK, LJ, LJ, LJ, LJ, LS, LS, LJ};
        push_lines(q, q.size());
        expect_pkt(80, 1, 0);
        send(8'hFF, 8'h00, 8'h00, 1, -1, 1'b0, -1);

        // Underrun before second byte of a 3-byte packet
        q = '{LK, LJ, LK, LJ, LK, LJ, LK, LK, LK, LK, LJ, LK, LJ, LK, LK, LK,
              LK, LK, LK, LK, LK, LK, LK, LK, LS, LS, LJ};
        push_lines(q, q.size());
        expect_pkt(108, 1, 1);
        send(8'hC3, 8'h11, 8'h22, 3, 1, 1'b0, -1);

        // Stuffing across byte boundaries and a pending stuff bit before EOP
        build(8'hC3, 8'hFF, 8'hFF, 3);
        push_lines(tmp, tmp.size());
        expect_pkt(152, 3, 0);
        send(8'hC3, 8'hFF, 8'hFF, 3, -1, 1'b0, -1);

        // Reset in the middle of the first data byte
        build(8'hC3, 8'h55, 8'h00, 2);
        push_lines(tmp, 13);
        expect_pkt(50, 1, 0);
        send(8'hC3, 8'h55, 8'h00, 2, -1, 1'b0, 48);

        // Fresh request right after reset release
        q = '{LK, LJ, LK, LJ, LK, LJ, LK, LK, LJ, LJ, LK, LJ, LJ, LK, LK, LK, LS, LS, LJ};
        push_lines(q, q.size());
        expect_pkt(76, 1, 0);
        send(8'hD2, 8'h00, 8'h00, 1, -1, 1'b0, -1);

`ifdef USB_TX_CRC16_EN
        // PID alone with CRC16 appended: empty payload sends 0x0000
        build(8'hC3, 8'h00, 8'h00, 3);
        push_lines(tmp, tmp.size());
        expect_pkt(140, 1, 0);
        append_req = 1'b1;
        send(8'hC3, 8'h00, 8'h00, 1, -1, 1'b0, -1);
        append_req = 1'b0;
`endif

        repeat (20) @(posedge clk48);
        chk("line_queue_drained", exp_line.size(), 0);
        chk("pkt_queue_drained", exp_pkt.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
